// File: rtl/mac_accum_requant.sv
// Accumulates LEN signed products per group, then round-half-up shifts and saturates to WIDTH bits.
// Optional build macro MAC_ACCUM_RELU_EN clamps negative results to zero before saturation.
module mac_accum_requant #(
   parameter int WIDTH       = 8,
   parameter int ACC_WIDTH   = 32,
   parameter int LEN         = 9,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*WIDTH-1:0]     in_data,
   input  logic [SHIFT_WIDTH-1:0] shift,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_sat
);

   localparam int IN_WIDTH = 2 * WIDTH;
   localparam int CNT_W    = (LEN < 2) ? 1 : $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);
   localparam logic [31:0] S_MAX = 32'(ACC_WIDTH - 1);

   localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH+1)'(2**(WIDTH-1) - 1);
   localparam logic signed [ACC_WIDTH:0] MIN_V = -((ACC_WIDTH+1)'(2**(WIDTH-1)));
   localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, ROUND, HOLD} state_t;

   state_t                   state_q, state_d;
   logic [ACC_WIDTH-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]         out_data_q, out_data_d;
   logic                     out_sat_q, out_sat_d;
   logic                     out_valid_q, out_valid_d;

   logic [ACC_WIDTH-1:0]     in_ext;
   logic [31:0]              s_amt;
   logic signed [ACC_WIDTH:0] acc_ext, bias, rnd_sum, r;
   logic [WIDTH-1:0]         rq_data;
   logic                     rq_sat;

   assign in_ext = ACC_WIDTH'($signed(in_data[IN_WIDTH-1:0]));

   // One extra bit of headroom so adding the rounding bias can never overflow.
   always_comb begin
      s_amt   = (32'(shift_q) > S_MAX) ? S_MAX : 32'(shift_q);
      acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
      bias    = (s_amt != 32'd0) ? ((ACC_WIDTH+1)'(1) <<< (s_amt - 32'd1)) : '0;
      rnd_sum = acc_ext + bias;
      r       = rnd_sum >>> s_amt;
`ifdef MAC_ACCUM_RELU_EN
      if (r < 0) begin
         r = '0;
      end
`endif
      rq_sat  = 1'b0;
      rq_data = r[WIDTH-1:0];
      if (r > MAX_V) begin
         rq_data = MAX_W;
         rq_sat  = 1'b1;
      end else if (r < MIN_V) begin
         rq_data = MIN_W;
         rq_sat  = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = in_ext;
               cnt_d   = CNT_W'(1);
               shift_d = shift;
               state_d = (LEN == 1) ? ROUND : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d = acc_q + in_ext;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == LEN_C) begin
                  state_d = ROUND;
               end
            end
         end
         ROUND: begin
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         shift_q     <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = ~rst & ((state_q == IDLE) || (state_q == ACCUM));
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_accum_requant.sv
// Self-checking bench for mac_accum_requant (defaults WIDTH=8, ACC_WIDTH=32, LEN=9, SHIFT_WIDTH=5).
module tb_mac_accum_requant;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [4:0]  shift;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_sat;

   int checks = 0;
   int errors = 0;

   mac_accum_requant #(.WIDTH(8), .ACC_WIDTH(32), .LEN(9), .SHIFT_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .shift(shift), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: floor((sum + half) / 2^s), then optional ReLU, then clip to int8.
   function automatic void model(input longint sum, input int sh, output int ed, output int es);
      longint s, d, num, q;
      s   = (sh > 31) ? 31 : sh;
      d   = 64'sd1 << s;
      num = sum + ((s > 0) ? d / 2 : 0);
      q   = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
`ifdef MAC_ACCUM_RELU_EN
      if (q < 0) q = 0;
`endif
      es = 0;
      if (q > 127) begin q = 127; es = 1; end
      else if (q < -128) begin q = -128; es = 1; end
      ed = int'(q);
   endfunction

   task automatic send_beat(input int d, input int sh, input bit bubble);
      int t;
      if (bubble) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 16'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'(d);
      shift    = 5'(sh);
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("beat_accept_timeout", 0, 1);
      @(posedge clk);
   endtask

   task automatic end_beats();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called at a negedge; waits for out_valid, optionally stalls, then completes one transfer.
   task automatic get_result(input int stall, output int d, output int s);
      int t;
      t = 0;
      d = 0;
      s = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         chk("out_valid_timeout", 0, 1);
         return;
      end
      d = int'($signed(out_data));
      s = int'(out_sat);
      for (int i = 0; i < stall; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = 16'($urandom);
         @(negedge clk);
         chk("hold_data", longint'($signed(out_data)), d);
         chk("hold_sat", out_sat, s);
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_after_transfer", out_valid, 0);
   endtask

   task automatic run_group(input int sh, input int a, input int b, input bit bub,
                            input int stall, output int d, output int s);
      for (int i = 0; i < 8; i++) send_beat(a, sh, bub);
      send_beat(b, sh, bub);
      end_beats();
      get_result(stall, d, s);
   endtask

   typedef struct {
      int    shift;
      int    a;       // value of beats 1..8
      int    b;       // value of beat 9
      int    exp_d;
      int    exp_s;
      string name;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int d, s, ed, es, n_high;
      longint sum;

      vecs[0]  = '{2,     1,     2,    3, 0, "round_pos_10_s2"};
      vecs[1]  = '{2,    -1,    -2,   -2, 0, "round_neg_10_s2"};
      vecs[2]  = '{0,    -1,     1,   -7, 0, "neg7_s0"};
      vecs[3]  = '{4,  1000,  1000,  127, 1, "sat_pos"};
      vecs[4]  = '{4, -1000, -1000, -128, 1, "sat_neg"};
      vecs[5]  = '{1,     0,     5,    3, 0, "half_up_2p5"};
      vecs[6]  = '{1,     0,    -5,   -2, 0, "half_up_m2p5"};
      vecs[7]  = '{1,     0,    -1,    0, 0, "half_up_m0p5"};
      vecs[8]  = '{0,    16,    -1,  127, 0, "edge_127"};
      vecs[9]  = '{0,    16,     0,  127, 1, "edge_128"};
      vecs[10] = '{0,   -16,     0, -128, 0, "edge_m128"};
      vecs[11] = '{0,   -16,    -1, -128, 1, "edge_m129"};
      vecs[12] = '{31, 32767, 32767,   0, 0, "shift_max"};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; shift = '0;
      #3;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1);

      // Sum and latency: 1..9 back-to-back, shift 0.
      for (int i = 1; i <= 9; i++) send_beat(i, 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat_edge_k", out_valid, 0);
      @(negedge clk);
      chk("lat_edge_k1", out_valid, 1);
      chk("sum45_data", longint'($signed(out_data)), 45);
      chk("sum45_sat", out_sat, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("lat_one_cycle", out_valid, 0);

      // Table-driven vectors.
      foreach (vecs[i]) begin
         ed = vecs[i].exp_d;
         es = vecs[i].exp_s;
`ifdef MAC_ACCUM_RELU_EN
         if (ed < 0) begin ed = 0; es = 0; end
`endif
         run_group(vecs[i].shift, vecs[i].a, vecs[i].b, 1'b0, 0, d, s);
         chk({vecs[i].name, "_data"}, d, ed);
         chk({vecs[i].name, "_sat"}, s, es);
      end

      // Backpressure: 5-cycle stall with in_valid pulses, then next group.
      run_group(4, 1000, 1000, 1'b0, 5, d, s);
      chk("bp_data", d, 127);
      chk("bp_sat", s, 1);
      for (int i = 1; i <= 9; i++) send_beat(i, 0, 1'b0);
      end_beats();
      get_result(0, d, s);
      chk("bp_next_data", d, 45);

      // Bubbles with shift changing after the first beat.
      send_beat(1, 0, 1'b0);
      for (int i = 2; i <= 9; i++) send_beat(i, 7, 1'b1);
      end_beats();
      get_result(0, d, s);
      chk("bubble_data", d, 45);
      chk("bubble_sat", s, 0);

      // Reset mid-group.
      for (int i = 0; i < 4; i++) send_beat(100, 0, 1'b0);
      end_beats();
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_out_sat", out_sat, 0);
      @(negedge clk);
      rst = 1'b0;
      n_high = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) n_high++;
      end
      chk("midrst_no_output", n_high, 0);
      run_group(1, 2, 2, 1'b0, 0, d, s);
      chk("after_rst_data", d, 9);

      // Reset while holding a result.
      for (int i = 0; i < 9; i++) send_beat(50, 0, 1'b0);
      end_beats();
      @(negedge clk);
      chk("hold_before_rst", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("hold_rst_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("hold_rst_stays_idle", out_valid, 0);

      // Randomized groups against the reference model.
      for (int g = 0; g < 40; g++) begin
         int sh, v, stall;
         sh = (g % 2 == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 31));
         stall = int'($urandom_range(0, 3));
         sum = 0;
         for (int i = 0; i < 9; i++) begin
            v = int'($signed(16'($urandom)));
            sum += v;
            send_beat(v, (i == 0) ? sh : int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         end
         end_beats();
         get_result(stall, d, s);
         model(sum, sh, ed, es);
         chk("rand_data", d, ed);
         chk("rand_sat", s, es);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
